// File: rtl/haraka_256_inv_perm.sv
// haraka_256_inv_perm
//   Iterative inverse of the 5-round Haraka-256 v2 permutation P. Given P(x) on
//   in_data it recovers x, running UNROLL inverse AES steps per lane per cycle
//   (10 or 5 step-cycles per job).
//   Lane byte order: byte 0 of a 128-bit lane sits in [127:120]. AES column c
//   holds bytes 4c..4c+3.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready is high only while IDLE
//   in_data[255:0]       P(x), w0 = [255:224] .. w7 = [31:0]
//   out_valid/out_ready  output handshake
//   out_data[255:0]      recovered x, held until the next result
//   busy                 high while steps are executing
module haraka_256_inv_perm #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q;
    logic [3:0]   step_cnt_q;
    logic [255:0] data_q, data_d;
    logic [255:0] out_data_q;
    logic         out_valid_q;
    logic         last_step;

    // Byte-swapped Haraka v2 round constants (byte 0 in the MSB).
    function automatic logic [127:0] rc_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  rc_rom = 128'h9d7b8175_f0fec5b2_0ac020e6_4c708406;
            5'd1:  rc_rom = 128'h17f7082f_a46b0f64_6ba0f388_e1b4668b;
            5'd2:  rc_rom = 128'h1491029f_609d02cf_9884f253_2dde0234;
            5'd3:  rc_rom = 128'h794f5bfd_afbcf3bb_084f7b2e_e6ead60e;
            5'd4:  rc_rom = 128'h447039be_1ccdee79_8b447248_cbb0cfcb;
            5'd5:  rc_rom = 128'h7b058a2b_ed35538d_b732906e_eecdea7e;
            5'd6:  rc_rom = 128'h1bef4fda_612741e2_d07c2e5e_438fc267;
            5'd7:  rc_rom = 128'h3b0bc71f_e2fd5f67_07cccaaf_b0d92429;
            5'd8:  rc_rom = 128'hee65d4b9_ca8fdbec_e97f86e6_f1634dab;
            5'd9:  rc_rom = 128'h337e03ad_4f402a5b_64cdb7d4_84bf301c;
            5'd10: rc_rom = 128'h0098f68d_2e8b0269_bf231794_b90bccb2;
            5'd11: rc_rom = 128'h8a2d9d5c_c89eaa4a_72556fde_a67804fa;
            5'd12: rc_rom = 128'hd49f1229_2e4ffa0e_122a776b_2b9fb4df;
            5'd13: rc_rom = 128'hee126abb_ae11d632_36a249f4_4403a11e;
            5'd14: rc_rom = 128'ha6eca89c_c900965f_8400054b_884904af;
            5'd15: rc_rom = 128'hec93e527_e3c7a278_4f9c199d_d85e0221;
            5'd16: rc_rom = 128'h7301d482_cd2e28b9_b7c959a7_f8aa3abf;
            5'd17: rc_rom = 128'h6b7d3010_d9eff237_17b08661_0d706062;
            5'd18: rc_rom = 128'hc69afcf6_5391c281_43043021_c245ca5a;
            5'd19: rc_rom = 128'h3a94d136_e892af2c_bb686b22_3c972392;
            default: rc_rom = '0;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); 254 has bits 1..7 set.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse affine map followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] z;
        z = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(z);
    endfunction

    // x = InvSB(InvSR(InvMC(y ^ rk)))
    function automatic logic [127:0] inv_aes_step(input logic [127:0] y, input logic [127:0] rk);
        logic [127:0] s, o;
        logic [7:0]   a [16];
        logic [7:0]   m [16];
        s = y ^ rk;
        for (int unsigned i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                m[4*c + r] = gf_mul(a[4*c + r],           8'h0e) ^
                             gf_mul(a[4*c + (r + 1) % 4], 8'h0b) ^
                             gf_mul(a[4*c + (r + 2) % 4], 8'h0d) ^
                             gf_mul(a[4*c + (r + 3) % 4], 8'h09);
        // InvShiftRows is folded into the gather: row r comes from column c - r.
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = inv_sbox(m[4*((c + 4 - r) % 4) + r]);
        return o;
    endfunction

    // Inverse step k undoes forward step 9-k, which used rc[2(9-k)] / rc[2(9-k)+1].
    // Even k undoes the second half of a round, so the word mix is removed first.
    function automatic logic [255:0] inv_round_step(input logic [255:0] s, input logic [3:0] k);
        logic [255:0] u;
        logic [4:0]   ih;
        if (!k[0]) u = {s[255:224], s[191:160], s[127:96], s[63:32],
                        s[223:192], s[159:128], s[95:64],  s[31:0]};
        else       u = s;
        ih = 5'd18 - {k, 1'b0};
        return {inv_aes_step(u[255:128], rc_rom(ih)),
                inv_aes_step(u[127:0],   rc_rom(ih | 5'd1))};
    endfunction

    always_comb begin
        data_d = data_q;
        for (int unsigned u = 0; u < UNROLL; u++)
            data_d = inv_round_step(data_d, step_cnt_q + 4'(u));
    end

    assign last_step = (step_cnt_q == 4'(10 - UNROLL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    data_q     <= in_data;
                    step_cnt_q <= '0;
                    state_q    <= RUN;
                end
                RUN: begin
                    data_q     <= data_d;
                    step_cnt_q <= step_cnt_q + 4'(UNROLL);
                    if (last_step) begin
                        step_cnt_q  <= '0;
                        out_data_q  <= data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_haraka_256_inv_perm.sv
// Testbench for haraka_256_inv_perm: one instance per UNROLL value (1 and 2).
// A forward Haraka-256 v2 permutation model generates P(x); the DUT must return x.
module tb_haraka_256_inv_perm;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [255:0] in_data   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [255:0] out_data  [2];
    logic         busy      [2];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  sbox [256];

    always #5 clk = ~clk;

    haraka_256_inv_perm #(.UNROLL(1)) u_dut_u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    haraka_256_inv_perm #(.UNROLL(2)) u_dut_u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    // Round constants exactly as the reference code's _mm_set_epi32 arguments (little-endian lanes).
    localparam logic [127:0] RC_RAW [20] = '{
        128'h0684704c_e620c00a_b2c5fef0_75817b9d, 128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
        128'h3402de2d_53f28498_cf029d60_9f029114, 128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
        128'hcbcfb0cb_4872448b_79eecd1c_be397044, 128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
        128'h67c28f43_5e2e7cd0_e2412761_da4fef1b, 128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
        128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee, 128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
        128'hb2cc0bb9_941723bf_69028b2e_8df69800, 128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
        128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4, 128'h1ea10344_f449a236_32d611ae_bb6a12ee,
        128'haf044988_4b050084_5f9600c9_9ca8eca6, 128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
        128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173, 128'h6260700d_6186b017_37f2efd9_10307d6b,
        128'h5aca45c2_21300443_81c29153_f6fc9ac6, 128'h9223973c_226b68bb_2caf92e8_36d1943a
    };

    // ---------------- reference model: forward permutation ----------------
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        logic [15:0] t;
        t = {v, v};
        return t[15 - n -: 8];
    endfunction

    // S-box from a log/antilog table over generator 3, then the AES affine map.
    task automatic build_sbox();
        logic [7:0]  pw [255];
        int unsigned lg [256];
        logic [7:0]  p, v;
        p = 8'h01;
        for (int unsigned i = 0; i < 255; i++) begin
            pw[i] = p;
            lg[p] = i;
            p = p ^ xt(p);
        end
        for (int unsigned x = 0; x < 256; x++) begin
            if (x == 0) v = 8'h00;
            else        v = pw[(255 - lg[x]) % 255];
            sbox[x] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] rc(input int unsigned i);
        logic [127:0] raw, v;
        raw = RC_RAW[i];
        v = {<<8{raw}};
        return v;
    endfunction

    // y = MC(SR(SB(x))) ^ k
    function automatic logic [127:0] aes_fwd(input logic [127:0] x, input logic [127:0] k);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++) b[i] = sbox[x[127 - 8*i -: 8]];
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                s[4*c + r] = b[4*((c + r) % 4) + r];
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = xt(s[4*c + r]) ^ xt(s[4*c + (r + 1) % 4]) ^
                                            s[4*c + (r + 1) % 4] ^ s[4*c + (r + 2) % 4] ^
                                            s[4*c + (r + 3) % 4];
        return o ^ k;
    endfunction

    function automatic logic [255:0] perm(input logic [255:0] x);
        logic [127:0] hi, lo;
        logic [255:0] s;
        hi = x[255:128];
        lo = x[127:0];
        for (int unsigned t = 0; t < 5; t++) begin
            for (int unsigned m = 0; m < 2; m++) begin
                hi = aes_fwd(hi, rc(4*t + 2*m));
                lo = aes_fwd(lo, rc(4*t + 2*m + 1));
            end
            s = {hi[127:96], lo[127:96], hi[95:64], lo[95:64],
                 hi[63:32],  lo[63:32],  hi[31:0],  lo[31:0]};
            hi = s[255:128];
            lo = s[127:0];
        end
        return {hi, lo};
    endfunction

    // ---------------- bench utilities ----------------
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int unsigned lat_of(input int unsigned d);
        return (d == 0) ? 10 : 5;
    endfunction

    function automatic string tg(input int unsigned d, input string s);
        return $sformatf("u%0d_%s", d + 1, s);
    endfunction

    task automatic accept(input int unsigned d, input logic [255:0] y, input string tag);
        check(tg(d, {tag, "_in_ready"}), in_ready[d], 256'd1);
        in_data[d]  = y;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        check(tg(d, {tag, "_busy"}), busy[d], 256'd1);
    endtask

    task automatic wait_valid(input int unsigned d, output int unsigned cyc);
        cyc = 0;
        while (out_valid[d] !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Full job with out_ready already high: result, latency, and one-cycle DONE.
    task automatic run_job(input int unsigned d, input logic [255:0] x, input string tag);
        int unsigned cyc;
        out_ready[d] = 1'b1;
        accept(d, perm(x), tag);
        wait_valid(d, cyc);
        check(tg(d, {tag, "_latency"}), 256'(cyc), 256'(lat_of(d)));
        check(tg(d, {tag, "_data"}), out_data[d], x);
        tick();
        check(tg(d, {tag, "_idle_after"}), in_ready[d], 256'd1);
        check(tg(d, {tag, "_valid_cleared"}), out_valid[d], 256'd0);
    endtask

    task automatic backpressure(input int unsigned d);
        logic [255:0] x;
        int unsigned  cyc;
        x = rand256();
        out_ready[d] = 1'b0;
        accept(d, perm(x), "bp");
        wait_valid(d, cyc);
        check(tg(d, "bp_latency"), 256'(cyc), 256'(lat_of(d)));
        for (int unsigned i = 0; i < 7; i++) begin
            check(tg(d, "bp_data_hold"), out_data[d], x);
            check(tg(d, "bp_valid_hold"), out_valid[d], 256'd1);
            check(tg(d, "bp_in_ready_low"), in_ready[d], 256'd0);
            if (i == 2) begin
                in_data[d]  = perm(rand256());
                in_valid[d] = 1'b1;
            end
            if (i == 4) in_valid[d] = 1'b0;
            tick();
        end
        out_ready[d] = 1'b1;
        tick();
        check(tg(d, "bp_release_idle"), in_ready[d], 256'd1);
        check(tg(d, "bp_release_valid"), out_valid[d], 256'd0);
        check(tg(d, "bp_data_kept"), out_data[d], x);
        check(tg(d, "bp_not_captured"), busy[d], 256'd0);
    endtask

    task automatic ignored(input int unsigned d);
        logic [255:0] x1;
        int unsigned  cyc;
        x1 = rand256();
        out_ready[d] = 1'b1;
        accept(d, perm(x1), "ign");
        tick();
        in_data[d]  = perm(rand256());
        in_valid[d] = 1'b1;
        check(tg(d, "ign_in_ready_low"), in_ready[d], 256'd0);
        tick();
        tick();
        in_valid[d] = 1'b0;
        wait_valid(d, cyc);
        check(tg(d, "ign_latency"), 256'(cyc + 3), 256'(lat_of(d)));
        check(tg(d, "ign_data"), out_data[d], x1);
        tick();
        tick();
        check(tg(d, "ign_stays_idle"), busy[d], 256'd0);
    endtask

    task automatic reset_mid(input int unsigned d);
        logic seen;
        out_ready[d] = 1'b1;
        accept(d, perm(rand256()), "rst");
        repeat (4 / (d + 1)) tick();
        check(tg(d, "rst_busy_before"), busy[d], 256'd1);
        rst_n = 1'b0;
        #1;
        check(tg(d, "rst_out_valid"), out_valid[d], 256'd0);
        check(tg(d, "rst_out_data"), out_data[d], 256'd0);
        check(tg(d, "rst_in_ready"), in_ready[d], 256'd1);
        check(tg(d, "rst_busy"), busy[d], 256'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | out_valid[d];
        end
        check(tg(d, "rst_no_resume"), seen, 256'd0);
        run_job(d, rand256(), "post_rst");
    endtask

    task automatic stream(input int unsigned d);
        logic [255:0] xs [10];
        int unsigned  idx, got, cyc, last;
        logic         acc;
        for (int unsigned i = 0; i < 10; i++) xs[i] = rand256();
        out_ready[d] = 1'b1;
        idx = 0; got = 0; cyc = 0; last = 0;
        in_data[d]  = perm(xs[0]);
        in_valid[d] = 1'b1;
        while (got < 10 && cyc < 200) begin
            acc = in_valid[d] && in_ready[d];
            if (out_valid[d]) begin
                check(tg(d, "stream_data"), out_data[d], xs[got]);
                if (got > 0) check(tg(d, "stream_period"), 256'(cyc - last), 256'(lat_of(d) + 2));
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 10) in_data[d] = perm(xs[idx]);
                else          in_valid[d] = 1'b0;
            end
        end
        in_valid[d] = 1'b0;
        check(tg(d, "stream_count"), 256'(got), 256'd10);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        build_sbox();
        for (int unsigned d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int unsigned d = 0; d < 2; d++) begin
            check(tg(d, "reset_in_ready"), in_ready[d], 256'd1);
            check(tg(d, "reset_out_valid"), out_valid[d], 256'd0);
            check(tg(d, "reset_out_data"), out_data[d], 256'd0);
            check(tg(d, "reset_busy"), busy[d], 256'd0);
        end
        for (int unsigned d = 0; d < 2; d++) begin
            run_job(d, 256'd0, "zero");
            backpressure(d);
            ignored(d);
            reset_mid(d);
            for (int unsigned i = 0; i < 200; i++) run_job(d, rand256(), "roundtrip");
            stream(d);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/haraka_256_inv_perm.md
# haraka_256_inv_perm

Iterative inverse of the 5-round Haraka-256 v2 permutation P: the input is P(x) and the output is x. It runs the inverse AES steps, with inverse word-mixing and round constants in reverse order, under a valid/ready handshake on both sides. It sits beside haraka_256_v2 as its decoder, used for permutation checking and round-trip self-test. For a haraka_256_v2 result `out = P(in) ^ in`, the caller must supply P(in) (that is, `out ^ in`).

## Interface
- UNROLL, 1, inverse AES steps per lane per cycle; legal values 1 (10 step-cycles) or 2 (5 step-cycles).
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; equals (state == IDLE).
- in_data  input  256  P(x), with word w0 = [255:224] through w7 = [31:0].
- out_valid  output  1  out_data holds x.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  256  recovered x.
- busy  output  1  high in RUN.

## Operation
- Round constants rc[0..19] are the same 20 byte-swapped 128-bit constants used by haraka_256_v2, held in an internal ROM.
- The forward AES step is y = MC(SR(SB(x))) ^ rc. The inverse step is x = InvSB(InvSR(InvMC(y ^ rc))), using the same byte ordering as haraka_aes_step. There are two lane instances per unrolled step.
- Forward step index j runs 0..9, with round t = j/2 and sub-step m = j%2. The high lane uses rc[4t+2m] and the low lane uses rc[4t+2m+1].
- Inverse step k runs 0..9 and undoes forward step j = 9−k.
- When k is even (m = 1), the step first un-mixes the state: hi = {w0,w2,w4,w6}, lo = {w1,w3,w5,w7}. When k is odd, it uses hi = state[255:128] and lo = state[127:0] directly.
- Each step writes state = {InvStep(hi, rc_hi), InvStep(lo, rc_lo)}. After k = 9, state equals x.
- With UNROLL = 2, steps k and k+1 run in one cycle.
- Counter: step_cnt counts 0..9 and advances by UNROLL each RUN cycle.
- FSM:
  - IDLE → RUN on in_valid && in_ready. This edge captures in_data and clears step_cnt.
  - RUN → DONE on the cycle that executes the last step. That edge writes out_data and sets out_valid.
  - DONE → IDLE on out_ready. That edge clears out_valid.
- in_valid outside IDLE is ignored. The producer must hold its word until in_ready is high.
- No overlap: a new word is accepted only in IDLE.

## Timing
- Reset (async assert, sync-free release): state IDLE, out_valid 0, out_data 0, busy 0, step_cnt 0, in_ready 1.
- Latency, counted from the acceptance edge E0 to the edge that sets out_valid: 10 cycles (UNROLL = 1) or 5 cycles (UNROLL = 2).
- Throughput with out_ready held high and a continuously valid producer:
  - UNROLL = 1: one result per 12 cycles (accept, 10 steps, output handshake).
  - UNROLL = 2: one result per 7 cycles.
- While out_valid && !out_ready, out_data is stable and in_ready stays 0 indefinitely.
- If out_ready is already high when out_valid rises, the transfer occurs on the next edge (one DONE cycle minimum).
- Reset mid-RUN or in DONE aborts the job: no out_valid pulse, and the job is not resumed.
- Combinational path: in_ready depends only on state, with no combinational path from in_valid or out_ready to any output.

## Test plan
- Zero vector: in_data = haraka_256_v2(256'h0). Since the input is zero, P(0) equals the module output. Required: out_data = 256'h0, with out_valid high exactly 10 cycles after acceptance (5 with UNROLL = 2).
- Round trip: for 200 random x, in_data = haraka_256_v2(x) ^ x. Required: out_data = x for both UNROLL values, checked against a C/Python inverse model for each intermediate state.
- Backpressure: hold out_ready low for 7 cycles after out_valid. Required: out_data stable, out_valid held, in_ready 0, and an in_valid pulse with a new word ignored; then out_ready = 1 leads to IDLE on the next edge.
- Ignored input: present a second word during RUN, then drop it before IDLE. Required: it is never captured, and the first result is unaffected.
- Reset mid-operation: assert rst_n = 0 at step_cnt = 4. Required: out_valid 0, out_data 0, in_ready 1 immediately; the next job returns a correct result.
- Streaming: in_valid and out_ready tied high, 10 random vectors. Required: results in order, one every 12 cycles (UNROLL = 1) or 7 cycles (UNROLL = 2), all matching the model.
